// File: rtl/smc_seq_rx.sv
// smc_seq_rx -- collects a 6-beat packet of transistor operating points,
// keeps a running descending ranking of gm or id (chosen by mode on the first
// beat), then emits the sum or weighted sum of the top/bottom three.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        beat qualifier for W / V_GS / V_DS
//   mode[1:0]       [0]: 0=gm 1=id ; [1]: 0=three smallest 1=three largest
//   W, V_GS, V_DS   3-bit unsigned beat operands
//   out_valid       one-cycle result strobe
//   out_n[9:0]      result, zero when out_valid is low
//   pkt_cnt[7:0]    packets emitted (only when SMC_PKT_CNT_EN is defined)
//
// Optional feature macro: SMC_PKT_CNT_EN

// One ranking slot: keeps its value, takes the new value, or takes the value
// shifted down from the slot above, so the array stays sorted descending.
module smc_rank_cell (
  input  logic [6:0] x,
  input  logic [6:0] above,
  input  logic [6:0] self,
  output logic [6:0] nxt
);
  assign nxt = (self >= x) ? self : ((above >= x) ? x : above);
endmodule

module smc_seq_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [2:0] W,
  input  logic [2:0] V_GS,
  input  logic [2:0] V_DS,
  output logic       out_valid,
  output logic [9:0] out_n
`ifdef SMC_PKT_CNT_EN
  ,
  output logic [7:0] pkt_cnt
`endif
);
  localparam int NUM_BEATS = 6;

  typedef enum logic [1:0] {IDLE, COLLECT, CALC, OUT} state_t;

  state_t                        state, state_nxt;
  logic [2:0]                    cnt;
  logic [1:0]                    mode_q;
  logic [NUM_BEATS-1:0][6:0]     rank_q, rank_nxt;
  logic                          accept;
  logic                          sel_id;
  logic [2:0]                    v;
  logic [6:0]                    gm, id, x;
  logic [9:0]                    a, b, c, sum;

  assign accept = in_valid && (state == IDLE || state == COLLECT);
  // mode is only trusted on the first beat; afterwards the latched copy rules
  assign sel_id = (state == IDLE) ? mode[0] : mode_q[0];

  // Per-beat device model; 12-bit intermediates cover the worst case (252).
  always_comb begin
    v  = V_GS - 3'd1;
    gm = '0;
    id = '0;
    if (V_GS != 3'd0) begin
      if (v > V_DS) begin
        gm = 7'((12'(W) * 12'(V_DS) * 12'd2) / 12'd3);
        id = 7'((12'(W) * (12'd2 * 12'(v) * 12'(V_DS) - 12'(V_DS) * 12'(V_DS))) / 12'd3);
      end else begin
        gm = 7'((12'(W) * 12'(v) * 12'd2) / 12'd3);
        id = 7'((12'(W) * 12'(v) * 12'(v)) / 12'd3);
      end
    end
    x = sel_id ? id : gm;
  end

  // Storage starts each packet at zero; zeros fall off the bottom as real
  // values are inserted, so after six beats the array holds exactly them.
  for (genvar i = 0; i < NUM_BEATS; i++) begin : g_slot
    logic [6:0] above;
    if (i == 0) begin : g_top
      assign above = 7'h7F;
    end else begin : g_rest
      assign above = rank_q[i-1];
    end
    smc_rank_cell u_cell (
      .x     (x),
      .above (above),
      .self  (rank_q[i]),
      .nxt   (rank_nxt[i])
    );
  end

  always_comb begin
    a   = mode_q[1] ? 10'(rank_q[0]) : 10'(rank_q[3]);
    b   = mode_q[1] ? 10'(rank_q[1]) : 10'(rank_q[4]);
    c   = mode_q[1] ? 10'(rank_q[2]) : 10'(rank_q[5]);
    sum = mode_q[0] ? (10'd3 * a + 10'd4 * b + 10'd5 * c) : (a + b + c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = COLLECT;
      COLLECT: if (in_valid && cnt == 3'(NUM_BEATS - 1)) state_nxt = CALC;
      CALC:    state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mode_q    <= '0;
      rank_q    <= '0;
      out_valid <= 1'b0;
      out_n     <= '0;
    end else begin
      out_valid <= 1'b0;
      out_n     <= '0;
      if (accept) begin
        rank_q <= rank_nxt;
        cnt    <= cnt + 3'd1;
        if (state == IDLE) mode_q <= mode;
      end
      if (state == CALC) begin
        out_valid <= 1'b1;
        out_n     <= sum;
        rank_q    <= '0;
        cnt       <= '0;
      end
    end
  end

`ifdef SMC_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pkt_cnt <= '0;
    else if (state == CALC) pkt_cnt <= pkt_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_smc_seq_rx.sv
module tb_smc_seq_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] W = 3'd0, V_GS = 3'd0, V_DS = 3'd0;
  logic       out_valid;
  logic [9:0] out_n;
`ifdef SMC_PKT_CNT_EN
  logic [7:0] pkt_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] bw [6];
  logic [2:0] bg [6];
  logic [2:0] bd [6];

  always #5 clk = ~clk;

  smc_seq_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .out_valid (out_valid),
    .out_n     (out_n)
`ifdef SMC_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  task automatic load_ref_beats();
    bw = '{3'd3, 3'd7, 3'd1, 3'd2, 3'd5, 3'd6};
    bg = '{3'd3, 3'd7, 3'd2, 3'd4, 3'd5, 3'd3};
    bd = '{3'd1, 3'd7, 3'd3, 3'd2, 3'd0, 3'd5};
  endtask

  // Drives the six beats in bw/bg/bd. mode=m0 on beat 1, m_late afterwards.
  // gap_after: beat index before which 3 idle cycles are inserted (-1 none).
  // junk: keep in_valid high with other operands through CALC and OUT.
  // Returns the samples one and two cycles after the 6th beat, and a count of
  // cycles during the beats where out_valid or out_n was non-zero.
  task automatic drive_pkt(input logic [1:0] m0, input logic [1:0] m_late,
                           input int gap_after, input bit junk,
                           output logic v1, output logic v2,
                           output logic [9:0] n2, output int early_bad);
    early_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == gap_after) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (out_valid !== 1'b0 || out_n !== 10'd0) early_bad++;
          in_valid = 1'b0;
          W = 3'd7; V_GS = 3'd7; V_DS = 3'd7;
          mode = m_late;
        end
      end
      @(negedge clk);
      if (out_valid !== 1'b0 || out_n !== 10'd0) early_bad++;
      in_valid = 1'b1;
      W = bw[i]; V_GS = bg[i]; V_DS = bd[i];
      mode = (i == 0) ? m0 : m_late;
    end
    @(negedge clk);
    v1 = out_valid;
    in_valid = junk;
    W = 3'd7; V_GS = 3'd7; V_DS = 3'd7; mode = 2'd3;
    @(negedge clk);
    v2 = out_valid;
    n2 = out_n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++;
    if (out_n !== 10'd0) begin n_bad++; $display("FAIL reset_out_n got %0d want 0", out_n); end
`ifdef SMC_PKT_CNT_EN
    n_cmp++;
    if (pkt_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_modes();
    logic [1:0] modes [4];
    logic [9:0] exp [4];
    logic v1, v2;
    logic [9:0] n2;
    int eb;
    modes = '{2'd2, 2'd0, 2'd1, 2'd3};
    exp   = '{10'd38, 10'd2, 10'd9, 10'd309};
    load_ref_beats();
    for (int m = 0; m < 4; m++) begin
      drive_pkt(modes[m], modes[m], -1, 1'b0, v1, v2, n2, eb);
      n_cmp++;
      if (eb != 0) begin n_bad++; $display("FAIL mode%0d_early got %0d bad cycles want 0", m, eb); end
      n_cmp++;
      if (v1 !== 1'b0) begin n_bad++; $display("FAIL mode%0d_calc_valid got %b want 0", m, v1); end
      n_cmp++;
      if (v2 !== 1'b1) begin n_bad++; $display("FAIL mode%0d_out_valid got %b want 1", m, v2); end
      n_cmp++;
      if (n2 !== exp[m]) begin n_bad++; $display("FAIL mode%0d_out_n got %0d want %0d", m, n2, exp[m]); end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || out_n !== 10'd0)
        begin n_bad++; $display("FAIL mode%0d_after got v=%b n=%0d want v=0 n=0", m, out_valid, out_n); end
    end
  endtask

  task automatic test_cutoff();
    logic v1, v2;
    logic [9:0] n2;
    int eb;
    bw = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    bg = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    bd = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    drive_pkt(2'd3, 2'd3, -1, 1'b0, v1, v2, n2, eb);
    n_cmp++;
    if (v2 !== 1'b1) begin n_bad++; $display("FAIL cutoff_valid got %b want 1", v2); end
    n_cmp++;
    if (n2 !== 10'd0) begin n_bad++; $display("FAIL cutoff_out_n got %0d want 0", n2); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic v1, v2;
    logic [9:0] n2;
    int eb;
    load_ref_beats();
    // mode switches to 01 after the first beat; the packet must stay mode 10
    drive_pkt(2'd2, 2'd1, 2, 1'b0, v1, v2, n2, eb);
    n_cmp++;
    if (eb != 0) begin n_bad++; $display("FAIL gaps_early got %0d bad cycles want 0", eb); end
    n_cmp++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin n_bad++; $display("FAIL gaps_timing got v1=%b v2=%b want 0 1", v1, v2); end
    n_cmp++;
    if (n2 !== 10'd38) begin n_bad++; $display("FAIL gaps_out_n got %0d want 38", n2); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [9:0] val;
    load_ref_beats();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; mode = 2'd2;
      W = bw[i]; V_GS = bg[i]; V_DS = bd[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_n !== 10'd0)
      begin n_bad++; $display("FAIL midrst_async got v=%b n=%0d want v=0 n=0", out_valid, out_n); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    val = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin pulses++; val = out_n; end
      in_valid = 1'b1; mode = 2'd2;
      W = bw[i]; V_GS = bg[i]; V_DS = bd[i];
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin pulses++; val = out_n; end
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL midrst_pulses got %0d want 1", pulses); end
    n_cmp++;
    if (val !== 10'd38) begin n_bad++; $display("FAIL midrst_out_n got %0d want 38", val); end
`ifdef SMC_PKT_CNT_EN
    n_cmp++;
    if (pkt_cnt !== 8'd1) begin n_bad++; $display("FAIL midrst_pkt_cnt got %0d want 1", pkt_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    logic v1, v2;
    logic [9:0] n2;
    int eb;
    load_ref_beats();
    drive_pkt(2'd2, 2'd2, -1, 1'b1, v1, v2, n2, eb);
    n_cmp++;
    if (v2 !== 1'b1 || n2 !== 10'd38)
      begin n_bad++; $display("FAIL b2b_first got v=%b n=%0d want v=1 n=38", v2, n2); end
    // next packet's first beat lands in the cycle right after out_valid
    drive_pkt(2'd0, 2'd0, -1, 1'b0, v1, v2, n2, eb);
    n_cmp++;
    if (eb != 0) begin n_bad++; $display("FAIL b2b_early got %0d bad cycles want 0", eb); end
    n_cmp++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin n_bad++; $display("FAIL b2b_timing got v1=%b v2=%b want 0 1", v1, v2); end
    n_cmp++;
    if (n2 !== 10'd2) begin n_bad++; $display("FAIL b2b_second got %0d want 2", n2); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_after got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_cutoff();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
